mant_multiplier: RTL and testbench

//  Sequential shift-add multiplier for 24-bit FP mantissas; the multiplicative counterpart of the

---
 rtl/mant_multiplier_pkg.sv | 19 +
 rtl/mul_add24.sv | 17 +
 rtl/mant_multiplier.sv | 144 ++++++++++++++
 tb/tb_mant_multiplier.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mant_multiplier_pkg.sv
// Shared FPU definitions for the mantissa datapath: widths and the
// multiplier sequencing states.
package mant_multiplier_pkg;

  // Mantissa width including the hidden bit, and the full product width
  localparam int MANT_W = 24;
  localparam int PROD_W = 2 * MANT_W;

  // Iteration counter width; one extra bit so it never wraps in an operation
  localparam int CNT_W  = $clog2(MANT_W) + 1;

  // Multiplier sequencing: waiting for work, shift-add loop, result capture
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/mul_add24.sv
// Unsigned adder used for the partial-product accumulate of the shift-add
// multiplier. The sum is one bit wider than the operands so the carry out
// can be shifted back into the product register.
module mul_add24 #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  // Plain zero-extended add; carry lands in sum[W]
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/mant_multiplier.sv
// Sequential shift-add multiplier for floating-point mantissas. One operand
// pair is accepted per request; after WIDTH add/shift iterations the raw
// product is published together with a normalized mantissa and the guard
// and sticky bits the rounding stage needs.
module mant_multiplier
  import mant_multiplier_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               req,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   out,
  output logic               norm,
  output logic               guard,
  output logic               sticky,
  output logic               ready
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               norm_q, norm_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     acc_sum;
  logic               last_iter;

  // Upper half of the product register plus multiplicand, with carry out
  mul_add24 #(
    .W (WIDTH)
  ) u_acc (
    .a   (p_q[2*WIDTH-1:WIDTH]),
    .b   (m_q),
    .sum (acc_sum)
  );

  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // State register and all datapath/result flops; reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      p_q      <= '0;
      prod_q   <= '0;
      out_q    <= '0;
      norm_q   <= 1'b0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      p_q      <= p_d;
      prod_q   <= prod_d;
      out_q    <= out_d;
      norm_q   <= norm_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state: accept in IDLE, loop WIDTH times in RUN, one capture cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = RUN;
      RUN:     if (last_iter) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result updates; everything holds unless the state acts on it
  always_comb begin
    cnt_d    = cnt_q;
    m_d      = m_q;
    p_d      = p_q;
    prod_d   = prod_q;
    out_d    = out_q;
    norm_d   = norm_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    ready_d  = ready_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          m_d     = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      RUN: begin
        if (p_q[0]) begin
          p_d = {acc_sum, p_q[WIDTH-1:1]};
        end else begin
          p_d = {1'b0, p_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
      end
      FIN: begin
        prod_d  = p_q;
        ready_d = 1'b1;
        if (p_q[2*WIDTH-1]) begin
          norm_d   = 1'b1;
          out_d    = p_q[2*WIDTH-1:WIDTH];
          guard_d  = p_q[WIDTH-1];
          sticky_d = |p_q[WIDTH-2:0];
        end else begin
          norm_d   = 1'b0;
          out_d    = p_q[2*WIDTH-2:WIDTH-1];
          guard_d  = p_q[WIDTH-2];
          sticky_d = |p_q[WIDTH-3:0];
        end
      end
      default: begin
        ready_d = 1'b1;
      end
    endcase
  end

  assign prod   = prod_q;
  assign out    = out_q;
  assign norm   = norm_q;
  assign guard  = guard_q;
  assign sticky = sticky_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_mant_multiplier.sv
// Directed bench for the shift-add mantissa multiplier: hand-computed
// products, normalization flags, latency, request filtering while busy,
// back-to-back requests and asynchronous abort.
module tb_mant_multiplier;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [23:0] a;
  logic [23:0] b;
  logic [47:0] prod;
  logic [23:0] out;
  logic        norm;
  logic        guard;
  logic        sticky;
  logic        ready;

  int vectors     = 0;
  int miscompares = 0;
  int busy        = 0;

  mant_multiplier #(
    .WIDTH (24)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .req    (req),
    .prod   (prod),
    .out    (out),
    .norm   (norm),
    .guard  (guard),
    .sticky (sticky),
    .ready  (ready)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and every miscompare
  task automatic checkVal(input string tag, input logic [47:0] observed,
                          input logic [47:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every result output against hand-computed values
  task automatic checkOutput(input string tag, input logic [47:0] eProd,
                             input logic [23:0] eOut, input logic eNorm,
                             input logic eGuard, input logic eSticky);
    checkVal({tag, " prod"},   prod,          eProd);
    checkVal({tag, " out"},    48'(out),      48'(eOut));
    checkVal({tag, " norm"},   48'(norm),     48'(eNorm));
    checkVal({tag, " guard"},  48'(guard),    48'(eGuard));
    checkVal({tag, " sticky"}, 48'(sticky),   48'(eSticky));
  endtask

  // Present one operand pair with a single-cycle request
  task automatic applyStimulus(input logic [23:0] opA, input logic [23:0] opB);
    @(negedge clk);
    a   = opA;
    b   = opB;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Wait (bounded) for ready, optionally pulsing stray requests while busy;
  // the number of busy cycles seen must equal the fixed latency of 25
  task automatic waitDone(input string tag, input int pulse1, input int pulse2,
                          input bit holdReq);
    busy = 0;
    while (ready !== 1'b1 && busy < 40) begin
      busy++;
      if (!holdReq) begin
        if (busy == pulse1 || busy == pulse2) begin
          req = 1'b1;
          a   = 24'hFFFFFF;
          b   = 24'hFFFFFF;
        end else begin
          req = 1'b0;
        end
      end
      @(negedge clk);
    end
    if (!holdReq) req = 1'b0;
    checkVal({tag, " latency"}, 48'(busy), 48'd25);
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 1'b0;
    a     = '0;
    b     = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    checkVal("reset ready", 48'(ready), 48'd1);
    checkOutput("reset", 48'h0, 24'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 * 1.0
    applyStimulus(24'h800000, 24'h800000);
    waitDone("one", -1, -1, 1'b0);
    checkOutput("one", 48'h400000000000, 24'h800000, 1'b0, 1'b0, 1'b0);

    // 1.5 * 1.5, product needs the extra integer bit
    applyStimulus(24'hC00000, 24'hC00000);
    waitDone("onehalf", -1, -1, 1'b0);
    checkOutput("onehalf", 48'h900000000000, 24'h900000, 1'b1, 1'b0, 1'b0);

    // Largest mantissas
    applyStimulus(24'hFFFFFF, 24'hFFFFFF);
    waitDone("max", -1, -1, 1'b0);
    checkOutput("max", 48'hFFFFFE000001, 24'hFFFFFE, 1'b1, 1'b0, 1'b1);

    // Zero operand still takes the full latency and clears all outputs
    applyStimulus(24'h000000, 24'hABCDEF);
    waitDone("zero", -1, -1, 1'b0);
    checkOutput("zero", 48'h0, 24'h0, 1'b0, 1'b0, 1'b0);

    // Unnormalized product with guard set and sticky clear
    applyStimulus(24'hC00000, 24'h800001);
    waitDone("guard", -1, -1, 1'b0);
    checkOutput("guard", 48'h600000C00000, 24'hC00001, 1'b0, 1'b1, 1'b0);

    // Requests at busy cycles 3 and 10 are dropped, not queued
    applyStimulus(24'hC00000, 24'hC00000);
    waitDone("ignore", 3, 10, 1'b0);
    checkOutput("ignore", 48'h900000000000, 24'h900000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("ignore no-queue ready", 48'(ready), 48'd1);

    // Asynchronous reset at RUN cycle 12 aborts and clears immediately
    applyStimulus(24'hFFFFFF, 24'hFFFFFF);
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkVal("abort ready", 48'(ready), 48'd1);
    checkOutput("abort", 48'h0, 24'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(24'h800000, 24'h800000);
    waitDone("after-abort", -1, -1, 1'b0);
    checkOutput("after-abort", 48'h400000000000, 24'h800000, 1'b0, 1'b0, 1'b0);

    // Request held high: second operation starts on the first IDLE edge
    @(negedge clk);
    a   = 24'd3;
    b   = 24'd5;
    req = 1'b1;
    @(negedge clk);
    a   = 24'd7;
    b   = 24'd9;
    waitDone("held1", -1, -1, 1'b1);
    checkOutput("held1", 48'd15, 24'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkVal("held ready one cycle", 48'(ready), 48'd0);
    req = 1'b0;
    waitDone("held2", -1, -1, 1'b0);
    checkOutput("held2", 48'd63, 24'h0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
